// File: rtl/aes_sh_input_loader_if.sv
// Stream-side and core-side signals of the masked AES input loader.
// D is the number of shares per bit. Every data vector is bit-compact:
// the shares of bit i sit at [i*D +: D].
interface aes_sh_input_loader_if #(
  parameter int D = 2
);
  logic                 s_valid;
  logic                 s_ready;
  logic [32*D-1:0]      s_data;
  logic                 s_key_keep;
  logic                 m_valid;
  logic                 m_ready;
  logic [128*D-1:0]     sh_plaintext;
  logic [128*D-1:0]     sh_key;

  // Environment view: feeds beats in and acts as the AES core.
  modport master (
    output s_valid, s_data, s_key_keep, m_ready,
    input  s_ready, m_valid, sh_plaintext, sh_key
  );

  // Loader view.
  modport slave (
    input  s_valid, s_data, s_key_keep, m_ready,
    output s_ready, m_valid, sh_plaintext, sh_key
  );
endinterface

// File: rtl/aes_sh_input_loader.sv
// Collects four 32-bit masked plaintext words and, unless a stored key is
// reused, four masked key words. The full 128-bit block is then presented
// to the masked AES core. Shares are only ever copied, never combined.
// The core-facing data is forced to zero whenever m_valid is low, so the
// core never sees a partly loaded block.
module aes_sh_input_loader #(
  parameter int d = 2
) (
  input logic                 clk,
  input logic                 rst,
  aes_sh_input_loader_if.slave bus
);

  localparam int W = 32 * d;

  typedef enum logic [1:0] {
    LOAD_PT  = 2'd0,
    LOAD_KEY = 2'd1,
    PRESENT  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [1:0]       r_cnt;
  logic [1:0]       w_cnt_nxt;
  logic             r_key_stored;
  logic             w_key_stored_nxt;
  logic [128*d-1:0] r_pt;
  logic [128*d-1:0] r_key;

  logic             w_s_ready;
  logic             w_m_valid;
  logic             w_beat;
  logic             w_hs;
  logic             w_pt_we;
  logic             w_key_we;
  logic             w_pt_clr;

  // The handshake flags come only from the state register and rst.
  // That leaves no combinational path from s_* to m_*, or from m_ready to s_ready.
  assign w_s_ready = (r_state != PRESENT) & ~rst;
  assign w_m_valid = (r_state == PRESENT);
  assign w_beat    = bus.s_valid & w_s_ready;
  assign w_hs      = w_m_valid & bus.m_ready;

  // Next-state logic, beat counting and register write enables.
  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_key_stored_nxt = r_key_stored;
    w_pt_we          = 1'b0;
    w_key_we         = 1'b0;
    w_pt_clr         = 1'b0;
    case (r_state)
      LOAD_PT: begin
        if (w_beat) begin
          w_pt_we   = 1'b1;
          w_cnt_nxt = r_cnt + 2'd1;
          if (r_cnt == 2'd3) begin
            // A keep request is honoured only if a key is actually held.
            if (bus.s_key_keep && r_key_stored) begin
              w_state_nxt = PRESENT;
            end else begin
              w_state_nxt = LOAD_KEY;
            end
          end else begin
            w_state_nxt = LOAD_PT;
          end
        end else begin
          w_state_nxt = LOAD_PT;
        end
      end
      LOAD_KEY: begin
        if (w_beat) begin
          w_key_we  = 1'b1;
          w_cnt_nxt = r_cnt + 2'd1;
          if (r_cnt == 2'd3) begin
            w_state_nxt      = PRESENT;
            w_key_stored_nxt = 1'b1;
          end else begin
            w_state_nxt = LOAD_KEY;
          end
        end else begin
          w_state_nxt = LOAD_KEY;
        end
      end
      PRESENT: begin
        if (w_hs) begin
          w_state_nxt = LOAD_PT;
          w_pt_clr    = 1'b1;
        end else begin
          w_state_nxt = PRESENT;
        end
      end
      default: begin
        w_state_nxt = LOAD_PT;
        w_cnt_nxt   = 2'd0;
      end
    endcase
  end

  // Control state registers. Reset also forgets the stored key.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= LOAD_PT;
      r_cnt        <= 2'd0;
      r_key_stored <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_key_stored <= w_key_stored_nxt;
    end
  end

  // Share storage. Each beat lands in word slot cnt.
  // The plaintext is wiped once the core has taken it.
  // The key stays until new key beats overwrite it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pt  <= {(128*d){1'b0}};
      r_key <= {(128*d){1'b0}};
    end else begin
      if (w_pt_clr) begin
        r_pt <= {(128*d){1'b0}};
      end else if (w_pt_we) begin
        r_pt[r_cnt*W +: W] <= bus.s_data;
      end else begin
        r_pt <= r_pt;
      end
      if (w_key_we) begin
        r_key[r_cnt*W +: W] <= bus.s_data;
      end else begin
        r_key <= r_key;
      end
    end
  end

  assign bus.s_ready      = w_s_ready;
  assign bus.m_valid      = w_m_valid;
  assign bus.sh_plaintext = w_m_valid ? r_pt  : {(128*d){1'b0}};
  assign bus.sh_key       = w_m_valid ? r_key : {(128*d){1'b0}};

endmodule
